// File: rtl/nv_ram_rwsp_fifo_ctrl_if.sv
// Producer, consumer and rwsp RAM signals for the FIFO controller.
// master = controller side, slave = producer/consumer/RAM side.
interface nv_ram_rwsp_fifo_ctrl_if #(
  parameter int AW = 2,
  parameter int DW = 128
);
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;
  logic [AW-1:0] ram_wa;
  logic          ram_we;
  logic [DW-1:0] ram_di;
  logic [AW-1:0] ram_ra;
  logic          ram_re;
  logic          ram_ore;
  logic [DW-1:0] ram_dout;

  modport master (
    input  wr_pvld, wr_pd, rd_prdy, ram_dout,
    output wr_prdy, rd_pvld, rd_pd, ram_wa, ram_we, ram_di, ram_ra, ram_re, ram_ore
  );
  modport slave (
    output wr_pvld, wr_pd, rd_prdy, ram_dout,
    input  wr_prdy, rd_pvld, rd_pd, ram_wa, ram_we, ram_di, ram_ra, ram_re, ram_ore
  );
endinterface

// File: rtl/nv_ram_rwsp_fifo_ctrl.sv
// FIFO controller sequencing an rwsp RAM (registered ra + ore-gated dout) as a queue.
// Optional NV_RAM_FIFO_CTRL_FLUSH_EN adds a flush input that clears all state.
module nv_ram_rwsp_fifo_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 128
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef NV_RAM_FIFO_CTRL_FLUSH_EN
  input  logic                 flush,
`endif
  nv_ram_rwsp_fifo_ctrl_if.master bus,
  output logic [AW:0]          used_cnt
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   unread_cnt;
  logic          s1_vld, s2_vld;
  logic          kill, push, pop, adv2, issue;

  // kill masks every enable/handshake in a clearing cycle
`ifdef NV_RAM_FIFO_CTRL_FLUSH_EN
  assign kill = rst | flush;
`else
  assign kill = rst;
`endif

  assign bus.wr_prdy = !kill && (used_cnt != FULL);
  assign push        = bus.wr_pvld && bus.wr_prdy;
  assign bus.rd_pvld = !kill && s2_vld;
  assign pop         = bus.rd_pvld && bus.rd_prdy;
  assign adv2        = !kill && s1_vld && (!s2_vld || pop);
  assign issue       = !kill && (unread_cnt != '0) && (!s1_vld || adv2);

  // RAM address and output registers are the s1/s2 data stages
  assign bus.ram_we  = push;
  assign bus.ram_wa  = wr_ptr;
  assign bus.ram_di  = bus.wr_pd;
  assign bus.ram_re  = issue;
  assign bus.ram_ra  = rd_ptr;
  assign bus.ram_ore = adv2;
  assign bus.rd_pd   = bus.ram_dout;

  always_ff @(posedge clk) begin
    if (kill) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      unread_cnt <= '0;
      used_cnt   <= '0;
      s1_vld     <= 1'b0;
      s2_vld     <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      unread_cnt <= unread_cnt + (AW+1)'(push) - (AW+1)'(issue);
      used_cnt   <= used_cnt   + (AW+1)'(push) - (AW+1)'(pop);
      s1_vld     <= issue || (s1_vld && !adv2);
      s2_vld     <= adv2  || (s2_vld && !pop);
    end
  end
endmodule

// File: tb/tb_nv_ram_rwsp_fifo_ctrl.sv
// Directed + random bench for nv_ram_rwsp_fifo_ctrl with a behavioural rwsp RAM.
module tb_nv_ram_rwsp_fifo_ctrl;
  localparam int DEPTH = 4, AW = 2, DW = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [AW:0] used_cnt;
  int n_cmp = 0, n_err = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ra_q;

  nv_ram_rwsp_fifo_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  nv_ram_rwsp_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef NV_RAM_FIFO_CTRL_FLUSH_EN
    .flush    (flush),
`endif
    .bus      (bus.master),
    .used_cnt (used_cnt)
  );

  always #5 clk = ~clk;

  // rwsp RAM: registered read address, ore-gated output register
  always_ff @(posedge clk) begin
    if (bus.ram_we)  mem[bus.ram_wa] <= bus.ram_di;
    if (bus.ram_re)  ra_q <= bus.ram_ra;
    if (bus.ram_ore) bus.ram_dout <= mem[ra_q];
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (rst || flush) q.delete();
    else begin
      chk("sb_used", 128'(used_cnt), 128'(q.size()));
      if (bus.ram_ore && bus.rd_pvld && !bus.rd_prdy) chk("ore_stall", 1, 0);
      if (bus.rd_pvld && bus.rd_prdy) begin
        if (q.size() == 0) chk("sb_underflow", 1, 0);
        else chk("sb_data", bus.rd_pd, q.pop_front());
      end
      if (bus.wr_pvld && bus.wr_prdy) q.push_back(bus.wr_pd);
    end
  end

  task automatic drain();
    bus.wr_pvld = 1'b0;
    bus.rd_prdy = 1'b1;
    for (int i = 0; i < 50 && used_cnt != 0; i++) cyc();
    chk("drain", 128'(used_cnt), 0);
  endtask

  task automatic clear_midstream(input bit use_flush);
    drain();
    bus.rd_prdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.wr_pvld = 1'b1; bus.wr_pd = 128'hC0 + 128'(i); cyc();
    end
    bus.wr_pvld = 1'b0;
    repeat (3) cyc();
    chk("mid_used3", 128'(used_cnt), 3);
    chk("mid_pvld", 128'(bus.rd_pvld), 1);
    if (use_flush) flush = 1'b1; else rst = 1'b1;
    #1;
    chk("clr_pvld", 128'(bus.rd_pvld), 0);
    chk("clr_prdy", 128'(bus.wr_prdy), 0);
    chk("clr_re", 128'(bus.ram_re | bus.ram_ore | bus.ram_we), 0);
    cyc();
    rst = 1'b0; flush = 1'b0;
    #1;
    chk("post_used", 128'(used_cnt), 0);
    chk("post_pvld", 128'(bus.rd_pvld), 0);
    bus.wr_pvld = 1'b1; bus.wr_pd = 128'h55; bus.rd_prdy = 1'b1;
    cyc();
    bus.wr_pvld = 1'b0;
    for (int i = 0; i < 10 && !bus.rd_pvld; i++) cyc();
    chk("post_pvld55", 128'(bus.rd_pvld), 1);
    chk("post_pd55", bus.rd_pd, 128'h55);
    cyc();
  endtask

  initial begin
    bus.wr_pvld = 1'b1; bus.wr_pd = 128'hDEAD; bus.rd_prdy = 1'b1;
    repeat (2) cyc();
    chk("rst_prdy", 128'(bus.wr_prdy), 0);
    chk("rst_we", 128'(bus.ram_we), 0);
    chk("rst_pvld", 128'(bus.rd_pvld), 0);
    chk("rst_used", 128'(used_cnt), 0);
    // latency: push cycle 0 -> re 1 -> ore 2 -> pvld 3
    rst = 1'b0; bus.wr_pd = 128'hA;
    #1;
    chk("lat_prdy", 128'(bus.wr_prdy), 1);
    chk("lat_we", 128'(bus.ram_we), 1);
    chk("lat_wa", 128'(bus.ram_wa), 0);
    cyc(); bus.wr_pvld = 1'b0; #1;
    chk("lat_re", 128'(bus.ram_re), 1);
    chk("lat_ra", 128'(bus.ram_ra), 0);
    chk("lat_used1", 128'(used_cnt), 1);
    cyc();
    chk("lat_ore", 128'(bus.ram_ore), 1);
    chk("lat_pvld2", 128'(bus.rd_pvld), 0);
    cyc();
    chk("lat_pvld3", 128'(bus.rd_pvld), 1);
    chk("lat_pd", bus.rd_pd, 128'hA);
    cyc();
    chk("lat_empty", 128'(bus.rd_pvld), 0);
    chk("lat_used0", 128'(used_cnt), 0);
    // fill with consumer stalled
    bus.rd_prdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wr_pvld = 1'b1; bus.wr_pd = 128'hB0 + 128'(i); #1;
      chk("fill_prdy", 128'(bus.wr_prdy), 1);
      cyc();
    end
    bus.wr_pd = 128'hEE; #1;
    chk("full_used", 128'(used_cnt), 4);
    chk("full_prdy", 128'(bus.wr_prdy), 0);
    chk("full_we", 128'(bus.ram_we), 0);
    for (int i = 0; i < 10; i++) begin
      chk("stall_pvld", 128'(bus.rd_pvld), 1);
      chk("stall_pd", bus.rd_pd, 128'hB0);
      cyc();
    end
    // full with simultaneous pop still refuses the write
    bus.rd_prdy = 1'b1; #1;
    chk("fp_prdy", 128'(bus.wr_prdy), 0);
    chk("fp_we", 128'(bus.ram_we), 0);
    cyc();
    bus.wr_pvld = 1'b0; bus.rd_prdy = 1'b0; #1;
    chk("fp_used3", 128'(used_cnt), 3);
    chk("fp_prdy1", 128'(bus.wr_prdy), 1);
    chk("fp_next_pd", bus.rd_pd, 128'hB1);
    drain();
    // streaming 0..15
    bus.rd_prdy = 1'b1;
    for (int k = 0; k < 19; k++) begin
      bus.wr_pvld = (k < 16); bus.wr_pd = 128'(k); #1;
      if (k >= 3) begin
        chk("str_pvld", 128'(bus.rd_pvld), 1);
        chk("str_pd", bus.rd_pd, 128'(k - 3));
      end
      cyc();
    end
    bus.wr_pvld = 1'b0;
    drain();
    // random traffic, checked by the scoreboard
    for (int i = 0; i < 1000; i++) begin
      bus.wr_pvld = 1'($urandom_range(0, 1));
      bus.wr_pd   = {96'h0, 32'($urandom)};
      bus.rd_prdy = 1'($urandom_range(0, 1));
      cyc();
    end
    drain();
    clear_midstream(1'b0);
`ifdef NV_RAM_FIFO_CTRL_FLUSH_EN
    clear_midstream(1'b1);
`endif
    drain();
    chk("sb_empty", 128'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
